calc_centroid_div: RTL and testbench
====================================

# calc_centroid_div

Downstream stage of the Y-direction gravity accumulator: converts the three moment sums (S, SX, SY) into a fixed-point centroid (CX, CY) for the eye-position output. Both quotients are computed by one shared sequential restoring divider, one quotient bit per clock, X first then Y. `oBUSY` drives the accumulator's `iBUSY`, so the accumulator holds its sums until the division ends.

## Interface
- `SUM_S_WIDTH`, 20, width of S (pixel count)
- `SUM_SX_WIDTH`, 28, width of SX; SY has the same width
- `INT_WIDTH`, 10, integer bits of each centroid coordinate (covers 0..639)
- `FRAC_WIDTH`, 4, fractional bits of each centroid coordinate
- Derived QW = INT_WIDTH + FRAC_WIDTH (14 by default)

- `CCLK` in 1: single clock
- `RST` in 1: asynchronous reset, active-high
- `iSTART` in 1: start request; sampled only in IDLE
- `iSUM_S` in SUM_S_WIDTH: divisor
- `iSUM_SX` in SUM_SX_WIDTH: X dividend
- `iSUM_SY` in SUM_SX_WIDTH: Y dividend
- `oBUSY` out 1: high from the cycle after an accepted start through DONE
- `oVALID` out 1: one-cycle pulse when results are updated
- `oCX`, `oCY` out QW: centroid as unsigned INT.FRAC fixed point
- `oNO_TARGET` out 1: last result had S = 0
- `oOVF` out 1: last result saturated

## Operation
- States: IDLE, DIV_X, DIV_Y, DONE.
- **IDLE, iSTART = 1, iSUM_S ≠ 0**
  - Latch all three sums into internal registers.
  - Go to DIV_X with bit counter = QW-1.
- **IDLE, iSTART = 1, iSUM_S = 0**
  - Go directly to DONE.
  - Result: oCX = oCY = 0, oNO_TARGET = 1, oOVF = 0.
- **Division method:** dividend D' = D concatenated with FRAC_WIDTH zeros. Only the low QW quotient bits are produced, MSB first.
  - Initial partial remainder = D' >> QW.
  - If the initial remainder ≥ S, that axis overflows. Its quotient saturates to all ones, oOVF = 1 for this result, and the axis still spends its QW cycles.
- **Per-cycle step:** R = (R << 1) | next dividend bit. If R ≥ S, then R -= S and the quotient bit is 1; otherwise it is 0.
  - Partial remainder width is SUM_S_WIDTH+1; the compare is unsigned.
- **DIV_X** runs for QW cycles, then loads the Y operands and goes to DIV_Y.
- **DIV_Y** runs for QW cycles, then goes to DONE.
- **DONE** lasts one cycle.
  - oCX, oCY, oNO_TARGET and oOVF are registered on entry to DONE.
  - oVALID = 1 during DONE.
  - The next state is IDLE.
- **Output hold:** outputs keep their values until the next DONE.
- **iSTART outside IDLE** is ignored; there is no queueing.
- **Input stability:** after acceptance, changes on the sum inputs do not affect the running division.
- **Rounding:** the quotient is truncated toward zero.

## Timing
- **Reset:** all outputs 0, state IDLE, internal registers 0. Reset mid-division aborts it, and no oVALID is produced.
- **Start to first busy:** cycle 0 is the iSTART sample in IDLE; oBUSY = 1 from cycle 1.
- **Normal latency:** oVALID in cycle 2·QW+1 (29 by default). oBUSY falls in cycle 2·QW+2, so the accumulator sees its falling edge there.
- **S = 0 latency:** oVALID in cycle 1, and oBUSY = 1 for that cycle only.
- **Restart:** the earliest next accepted start is the cycle after DONE.
- **iSTART in DONE** is ignored.

## Structure
- **Shared package (`eyetracker_pkg`)**
  - Constants SUM_S_WIDTH, SUM_SX_WIDTH, INT_WIDTH, FRAC_WIDTH, QW.
  - The state encoding, 2 bits: IDLE=0, DIV_X=1, DIV_Y=2, DONE=3.
- **Sub-module `restoring_div_step`**
  - Purely combinational: inputs R, the incoming dividend bit and S; outputs the new R and the quotient bit.
  - Instantiated once and shared by both axes.
- **Top level:** FSM, bit counter, dividend shift register, quotient shift register and output registers.

## Test plan
- **Basic:** S=4, SX=400, SY=200, start → oVALID at cycle 29; oCX=0x640 (100.0), oCY=0x320 (50.0); oBUSY high cycles 1..29; flags 0.
- **Fraction:** S=3, SX=10, SY=1438 → oCX=53 (3.3125, truncated); oCY=7669 (479.3125).
- **Zero divisor:** S=0, SX=SY=123 → oVALID at cycle 1; oCX=oCY=0; oNO_TARGET=1; oBUSY high 1 cycle only.
- **Overflow:** S=1, SX=1024, SY=5 → oCX=0x3FFF, oCY=80, oOVF=1, latency still 29.
- **Busy:** iSTART re-pulsed at cycle 10 with new sums → ignored; results match the first operands; one oVALID only.
- **Reset:** assert RST at cycle 12 → oBUSY=0 and outputs 0 immediately; no oVALID. A start after release computes correctly.

Source files
------------

// File: rtl/eyetracker_pkg.sv
// Shared constants and types for the eye-tracker centroid datapath.
// Widths of the moment sums, the fixed-point format and the divider FSM encoding.
package eyetracker_pkg;

    localparam int SUM_S_WIDTH  = 20;
    localparam int SUM_SX_WIDTH = 28;
    localparam int INT_WIDTH    = 10;
    localparam int FRAC_WIDTH   = 4;
    localparam int QW           = INT_WIDTH + FRAC_WIDTH;

    // Scaled dividend width and partial-remainder width of the restoring divider
    localparam int DW = SUM_SX_WIDTH + FRAC_WIDTH;
    localparam int RW = SUM_S_WIDTH + 1;
    localparam int CW = $clog2(QW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    function automatic logic [DW-1:0] extend_dividend(input logic [SUM_SX_WIDTH-1:0] d);
        return {d, {FRAC_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One iteration of an unsigned restoring division: shift in a dividend bit,
// subtract the divisor when it fits and emit the quotient bit.
module restoring_div_step
    import eyetracker_pkg::*;
(
    input  logic [RW-1:0]          r,
    input  logic                   din,
    input  logic [SUM_S_WIDTH-1:0] s,
    output logic [RW-1:0]          r_next,
    output logic                   q
);

    logic [RW-1:0] trial;
    logic [RW-1:0] s_ext;

    always_comb begin
        trial  = {r[RW-2:0], din};
        s_ext  = RW'(s);
        r_next = trial;
        q      = 1'b0;
        if (trial >= s_ext) begin
            r_next = trial - s_ext;
            q      = 1'b1;
        end
    end

endmodule

// File: rtl/calc_centroid_div.sv
// Converts moment sums (S, SX, SY) into a fixed-point centroid using one
// shared bit-serial restoring divider, X axis first, then Y.
module calc_centroid_div
    import eyetracker_pkg::*;
(
    input  logic                    CCLK,
    input  logic                    RST,
    input  logic                    iSTART,
    input  logic [SUM_S_WIDTH-1:0]  iSUM_S,
    input  logic [SUM_SX_WIDTH-1:0] iSUM_SX,
    input  logic [SUM_SX_WIDTH-1:0] iSUM_SY,
    output logic                    oBUSY,
    output logic                    oVALID,
    output logic [QW-1:0]           oCX,
    output logic [QW-1:0]           oCY,
    output logic                    oNO_TARGET,
    output logic                    oOVF
);

    localparam logic [QW-1:0] SAT      = '1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(QW - 1);

    div_state_t              state;
    logic [SUM_S_WIDTH-1:0]  s_reg;
    logic [SUM_SX_WIDTH-1:0] sx_reg;
    logic [SUM_SX_WIDTH-1:0] sy_reg;
    logic [RW-1:0]           rem;
    logic [QW-1:0]           dbits;
    logic [QW-1:0]           quot;
    logic [QW-1:0]           cx_res;
    logic [CW-1:0]           cnt;
    logic                    axis_ovf;
    logic                    ovf_x;

    logic [DW-1:0]           dx_ext;
    logic [DW-1:0]           dy_ext;
    logic [RW-1:0]           rx_init;
    logic [RW-1:0]           ry_init;
    logic                    rx_ovf;
    logic                    ry_ovf;
    logic [RW-1:0]           rem_next;
    logic                    q_bit;
    logic [QW-1:0]           quot_next;

    // The upper part of the scaled dividend seeds the remainder; if it already
    // reaches S the quotient cannot fit in QW bits and the axis saturates.
    assign dx_ext    = extend_dividend(iSUM_SX);
    assign dy_ext    = extend_dividend(sy_reg);
    assign rx_init   = RW'(dx_ext >> QW);
    assign ry_init   = RW'(dy_ext >> QW);
    assign rx_ovf    = (rx_init >= RW'(iSUM_S));
    assign ry_ovf    = (ry_init >= RW'(s_reg));
    assign quot_next = {quot[QW-2:0], q_bit};

    restoring_div_step u_step (
        .r      (rem),
        .din    (dbits[QW-1]),
        .s      (s_reg),
        .r_next (rem_next),
        .q      (q_bit)
    );

    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            s_reg      <= '0;
            sx_reg     <= '0;
            sy_reg     <= '0;
            rem        <= '0;
            dbits      <= '0;
            quot       <= '0;
            cx_res     <= '0;
            cnt        <= '0;
            axis_ovf   <= 1'b0;
            ovf_x      <= 1'b0;
            oBUSY      <= 1'b0;
            oVALID     <= 1'b0;
            oCX        <= '0;
            oCY        <= '0;
            oNO_TARGET <= 1'b0;
            oOVF       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    oVALID <= 1'b0;
                    if (iSTART) begin
                        oBUSY <= 1'b1;
                        if (iSUM_S != '0) begin
                            s_reg    <= iSUM_S;
                            sx_reg   <= iSUM_SX;
                            sy_reg   <= iSUM_SY;
                            rem      <= rx_init;
                            dbits    <= dx_ext[QW-1:0];
                            quot     <= '0;
                            axis_ovf <= rx_ovf;
                            cnt      <= CNT_LOAD;
                            state    <= DIV_X;
                        end else begin
                            oCX        <= '0;
                            oCY        <= '0;
                            oNO_TARGET <= 1'b1;
                            oOVF       <= 1'b0;
                            oVALID     <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end

                DIV_X: begin
                    if (cnt == '0) begin
                        cx_res   <= axis_ovf ? SAT : quot_next;
                        ovf_x    <= axis_ovf;
                        rem      <= ry_init;
                        dbits    <= dy_ext[QW-1:0];
                        quot     <= '0;
                        axis_ovf <= ry_ovf;
                        cnt      <= CNT_LOAD;
                        state    <= DIV_Y;
                    end else begin
                        rem   <= rem_next;
                        dbits <= {dbits[QW-2:0], 1'b0};
                        quot  <= quot_next;
                        cnt   <= cnt - 1'b1;
                    end
                end

                DIV_Y: begin
                    if (cnt == '0) begin
                        oCX        <= cx_res;
                        oCY        <= axis_ovf ? SAT : quot_next;
                        oNO_TARGET <= 1'b0;
                        oOVF       <= ovf_x | axis_ovf;
                        oVALID     <= 1'b1;
                        state      <= DONE;
                    end else begin
                        rem   <= rem_next;
                        dbits <= {dbits[QW-2:0], 1'b0};
                        quot  <= quot_next;
                        cnt   <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    oVALID <= 1'b0;
                    oBUSY  <= 1'b0;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_centroid_div.sv
// Directed self-checking bench for calc_centroid_div: latency, quotients,
// zero divisor, overflow saturation, busy lock-out and mid-division reset.
module tb_calc_centroid_div;
    import eyetracker_pkg::*;

    logic                    CCLK;
    logic                    RST;
    logic                    iSTART;
    logic [SUM_S_WIDTH-1:0]  iSUM_S;
    logic [SUM_SX_WIDTH-1:0] iSUM_SX;
    logic [SUM_SX_WIDTH-1:0] iSUM_SY;
    logic                    oBUSY;
    logic                    oVALID;
    logic [QW-1:0]           oCX;
    logic [QW-1:0]           oCY;
    logic                    oNO_TARGET;
    logic                    oOVF;

    int checks = 0;
    int passes = 0;

    calc_centroid_div dut (
        .CCLK       (CCLK),
        .RST        (RST),
        .iSTART     (iSTART),
        .iSUM_S     (iSUM_S),
        .iSUM_SX    (iSUM_SX),
        .iSUM_SY    (iSUM_SY),
        .oBUSY      (oBUSY),
        .oVALID     (oVALID),
        .oCX        (oCX),
        .oCY        (oCY),
        .oNO_TARGET (oNO_TARGET),
        .oOVF       (oOVF)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Presents the sums with a one-cycle start, then scrambles the inputs so
    // any dependence on them after acceptance shows up in the results.
    task automatic applyStimulus(input logic [SUM_S_WIDTH-1:0] s,
                                 input logic [SUM_SX_WIDTH-1:0] sx,
                                 input logic [SUM_SX_WIDTH-1:0] sy);
        iSUM_S  = s;
        iSUM_SX = sx;
        iSUM_SY = sy;
        iSTART  = 1'b1;
        tick();
        iSTART  = 1'b0;
        iSUM_S  = 20'h5A5A5;
        iSUM_SX = 28'h0F0F0F0;
        iSUM_SY = 28'h1234567;
    endtask

    task automatic waitValid(input int start_cyc, output int lat, output bit busy_ok);
        int cyc;
        cyc     = start_cyc;
        busy_ok = 1'b1;
        lat     = -1;
        while (cyc <= 80) begin
            if (!oBUSY) busy_ok = 1'b0;
            if (oVALID) begin
                lat = cyc;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    initial begin
        int  lat;
        bit  busy_ok;
        int  vcount;

        RST     = 1'b1;
        iSTART  = 1'b0;
        iSUM_S  = '0;
        iSUM_SX = '0;
        iSUM_SY = '0;
        repeat (2) tick();
        checkOutput("reset_busy",  32'(oBUSY),  32'd0);
        checkOutput("reset_valid", 32'(oVALID), 32'd0);
        checkOutput("reset_cx",    32'(oCX),    32'd0);
        checkOutput("reset_flags", 32'({oNO_TARGET, oOVF}), 32'd0);
        RST = 1'b0;
        tick();

        // Basic: 6400/4 and 3200/4
        applyStimulus(20'd4, 28'd400, 28'd200);
        checkOutput("basic_busy_c1", 32'(oBUSY), 32'd1);
        waitValid(1, lat, busy_ok);
        checkOutput("basic_latency", 32'(lat), 32'd29);
        checkOutput("basic_busy_span", 32'(busy_ok), 32'd1);
        checkOutput("basic_cx", 32'(oCX), 32'h640);
        checkOutput("basic_cy", 32'(oCY), 32'h320);
        checkOutput("basic_flags", 32'({oNO_TARGET, oOVF}), 32'd0);

        // Start request during DONE must be dropped
        iSUM_S  = 20'd7;
        iSUM_SX = 28'd70;
        iSUM_SY = 28'd70;
        iSTART  = 1'b1;
        tick();
        iSTART  = 1'b0;
        checkOutput("done_start_ignored_busy",  32'(oBUSY),  32'd0);
        checkOutput("done_start_ignored_valid", 32'(oVALID), 32'd0);
        checkOutput("hold_cx", 32'(oCX), 32'h640);
        tick();

        // Truncated fractions: 160/3 = 53.33, 23008/3 = 7669.33
        applyStimulus(20'd3, 28'd10, 28'd1438);
        waitValid(1, lat, busy_ok);
        checkOutput("frac_latency", 32'(lat), 32'd29);
        checkOutput("frac_cx", 32'(oCX), 32'd53);
        checkOutput("frac_cy", 32'(oCY), 32'd7669);
        tick();

        // Zero divisor short path
        applyStimulus(20'd0, 28'd123, 28'd123);
        waitValid(1, lat, busy_ok);
        checkOutput("zero_latency", 32'(lat), 32'd1);
        checkOutput("zero_busy", 32'(oBUSY), 32'd1);
        checkOutput("zero_cx_cy", 32'({oCX, oCY}), 32'd0);
        checkOutput("zero_no_target", 32'(oNO_TARGET), 32'd1);
        checkOutput("zero_ovf", 32'(oOVF), 32'd0);
        tick();
        checkOutput("zero_busy_drop", 32'(oBUSY), 32'd0);
        tick();

        // Overflow on X only: 16384/1 saturates, 80/1 fits
        applyStimulus(20'd1, 28'd1024, 28'd5);
        waitValid(1, lat, busy_ok);
        checkOutput("ovf_latency", 32'(lat), 32'd29);
        checkOutput("ovf_cx", 32'(oCX), 32'h3FFF);
        checkOutput("ovf_cy", 32'(oCY), 32'd80);
        checkOutput("ovf_flag", 32'(oOVF), 32'd1);
        checkOutput("ovf_no_target", 32'(oNO_TARGET), 32'd0);
        tick();

        // Reset at cycle 12 aborts the division and clears outputs at once
        applyStimulus(20'd4, 28'd400, 28'd200);
        repeat (11) tick();
        RST = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(oBUSY), 32'd0);
        checkOutput("rst_cx_cy", 32'({oCX, oCY}), 32'd0);
        checkOutput("rst_ovf", 32'(oOVF), 32'd0);
        vcount = 0;
        repeat (3) begin
            tick();
            vcount += int'(oVALID);
        end
        RST = 1'b0;
        repeat (30) begin
            tick();
            vcount += int'(oVALID);
        end
        checkOutput("rst_no_valid", 32'(vcount), 32'd0);

        applyStimulus(20'd3, 28'd10, 28'd1438);
        waitValid(1, lat, busy_ok);
        checkOutput("post_rst_latency", 32'(lat), 32'd29);
        checkOutput("post_rst_cx", 32'(oCX), 32'd53);
        checkOutput("post_rst_cy", 32'(oCY), 32'd7669);
        tick();

        // Start re-pulsed at cycle 10 with other sums is ignored
        applyStimulus(20'd4, 28'd400, 28'd200);
        repeat (9) tick();
        iSUM_S  = 20'd3;
        iSUM_SX = 28'd10;
        iSUM_SY = 28'd1438;
        iSTART  = 1'b1;
        tick();
        iSTART  = 1'b0;
        waitValid(11, lat, busy_ok);
        checkOutput("busy_latency", 32'(lat), 32'd29);
        checkOutput("busy_cx", 32'(oCX), 32'h640);
        checkOutput("busy_cy", 32'(oCY), 32'h320);
        vcount = 0;
        repeat (35) begin
            tick();
            vcount += int'(oVALID);
        end
        checkOutput("busy_single_valid", 32'(vcount), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
